// File: rtl/lif_tdm_scheduler.sv
// Time-multiplexed leaky integrate-and-fire scheduler: one shared update datapath
// sweeps all neurons per tick and queues spikes in a small FIFO for the router.
module lif_tdm_scheduler #(
  parameter int N_NEURONS  = 4,
  parameter int THRESHOLD  = 200,
  parameter int DECAY      = 1,
  parameter int REFRACTORY = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_enable,
  input  logic                         i_tick,
  input  logic                         i_in_valid,
  input  logic [$clog2(N_NEURONS)-1:0] i_in_idx,
  input  logic [7:0]                   i_in_value,
  output logic                         o_busy,
  output logic                         o_sweep_done,
  output logic                         o_spike_valid,
  input  logic                         i_spike_ready,
  output logic [$clog2(N_NEURONS)-1:0] o_spike_idx,
  output logic                         o_spike_dropped,
  output logic [7:0]                   o_drop_count,
  input  logic [$clog2(N_NEURONS)-1:0] i_state_sel,
  output logic [7:0]                   o_state_out
);

  localparam int IW = $clog2(N_NEURONS);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int RW = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;
  localparam logic [7:0]    C_TH    = 8'(THRESHOLD);
  localparam logic [7:0]    C_DECAY = 8'(DECAY);
  localparam logic [RW-1:0] C_REFR  = RW'(REFRACTORY);
  localparam logic [FW:0]   C_DEPTH = (FW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_UPDATE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  state_t          r_state;
  state_t          w_next_state;
  logic            w_fetch;
  logic            w_update;
  logic            w_last;
  logic [IW-1:0]   r_ptr;
  logic            r_busy;
  logic            r_done;

  logic [7:0]      r_mem  [N_NEURONS];
  logic [7:0]      r_stim [N_NEURONS];
  logic [RW-1:0]   r_refr [N_NEURONS];

  logic [7:0]      r_s;
  logic [7:0]      r_x;
  logic [RW-1:0]   r_r;
  logic [7:0]      w_sum;
  logic [7:0]      w_leak;
  logic [7:0]      w_next;
  logic            w_fire;
  logic            w_fwd_hit;

  logic [IW-1:0]   r_fifo [FIFO_DEPTH];
  logic [FW-1:0]   r_wr;
  logic [FW-1:0]   r_rd;
  logic [FW:0]     r_cnt;
  logic            w_valid;
  logic            w_full;
  logic            w_pop;
  logic            w_push_ok;
  logic            w_drop;
  logic            r_dropped;
  logic [7:0]      r_drop_count;

  assign w_last = (r_ptr == IW'(N_NEURONS - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_tick && i_enable) w_next_state = S_FETCH;
        else                    w_next_state = S_IDLE;
      end
      S_FETCH:  w_next_state = S_UPDATE;
      S_UPDATE: begin
        if (w_last) w_next_state = S_DONE;
        else        w_next_state = S_FETCH;
      end
      S_DONE:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_fetch  = 1'b0;
    w_update = 1'b0;
    case (r_state)
      S_FETCH:  w_fetch  = 1'b1;
      S_UPDATE: w_update = 1'b1;
      default: begin
        w_fetch  = 1'b0;
        w_update = 1'b0;
      end
    endcase
  end

  // Status outputs are registered from the next state so they align with the state itself.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_ptr  <= '0;
    end else begin
      r_busy <= (w_next_state != S_IDLE);
      r_done <= (w_next_state == S_DONE);
      if (w_update) r_ptr <= r_ptr + IW'(1);
      else          r_ptr <= r_ptr;
    end
  end

  // A write landing on the neuron during its FETCH is folded into the latched stimulus.
  assign w_fwd_hit = i_in_valid && (i_in_idx == r_ptr);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_s <= 8'd0;
      r_x <= 8'd0;
      r_r <= '0;
    end else if (w_fetch) begin
      r_s <= r_mem[r_ptr];
      r_x <= w_fwd_hit ? sat_add(r_stim[r_ptr], i_in_value) : r_stim[r_ptr];
      r_r <= r_refr[r_ptr];
    end else begin
      r_s <= r_s;
      r_x <= r_x;
      r_r <= r_r;
    end
  end

  assign w_sum  = sat_add(r_s, r_x);
  assign w_leak = (r_s < C_DECAY) ? r_s : C_DECAY;
  assign w_next = w_sum - w_leak;
  assign w_fire = w_update && (r_r == RW'(0)) && (w_next >= C_TH);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        r_mem[i]  <= 8'd0;
        r_refr[i] <= RW'(0);
      end
    end else begin
      for (int i = 0; i < N_NEURONS; i++) begin
        if (w_update && (r_ptr == IW'(i))) begin
          if (r_r != RW'(0)) begin
            r_mem[i]  <= 8'd0;
            r_refr[i] <= r_r - RW'(1);
          end else if (w_next >= C_TH) begin
            r_mem[i]  <= 8'd0;
            r_refr[i] <= C_REFR;
          end else begin
            r_mem[i]  <= w_next;
            r_refr[i] <= RW'(0);
          end
        end else begin
          r_mem[i]  <= r_mem[i];
          r_refr[i] <= r_refr[i];
        end
      end
    end
  end

  // Clearing in UPDATE wins over accumulation; a coincident write seeds the next sweep.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < N_NEURONS; i++) r_stim[i] <= 8'd0;
    end else begin
      for (int i = 0; i < N_NEURONS; i++) begin
        if (w_update && (r_ptr == IW'(i))) begin
          if (i_in_valid && (i_in_idx == IW'(i))) r_stim[i] <= i_in_value;
          else                                    r_stim[i] <= 8'd0;
        end else if (i_in_valid && (i_in_idx == IW'(i))) begin
          r_stim[i] <= sat_add(r_stim[i], i_in_value);
        end else begin
          r_stim[i] <= r_stim[i];
        end
      end
    end
  end

  assign w_valid   = (r_cnt != (FW + 1)'(0));
  assign w_full    = (r_cnt == C_DEPTH);
  assign w_pop     = w_valid && i_spike_ready;
  assign w_push_ok = w_fire && (!w_full || w_pop);
  assign w_drop    = w_fire && w_full && !w_pop;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= IW'(0);
      r_wr         <= '0;
      r_rd         <= '0;
      r_cnt        <= '0;
      r_dropped    <= 1'b0;
      r_drop_count <= 8'd0;
    end else begin
      if (w_push_ok) begin
        r_fifo[r_wr] <= r_ptr;
        r_wr         <= r_wr + FW'(1);
      end else begin
        r_wr <= r_wr;
      end
      if (w_pop) r_rd <= r_rd + FW'(1);
      else       r_rd <= r_rd;
      case ({w_push_ok, w_pop})
        2'b10:   r_cnt <= r_cnt + (FW + 1)'(1);
        2'b01:   r_cnt <= r_cnt - (FW + 1)'(1);
        default: r_cnt <= r_cnt;
      endcase
      r_dropped <= w_drop;
      if (w_drop && (r_drop_count != 8'hFF)) r_drop_count <= r_drop_count + 8'd1;
      else                                   r_drop_count <= r_drop_count;
    end
  end

  assign o_busy          = r_busy;
  assign o_sweep_done    = r_done;
  assign o_spike_valid   = w_valid;
  assign o_spike_idx     = r_fifo[r_rd];
  assign o_spike_dropped = r_dropped;
  assign o_drop_count    = r_drop_count;
  assign o_state_out     = r_mem[i_state_sel];

endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// Randomized and directed bench for lif_tdm_scheduler against a cycle-level
// behavioural model built from the neuron update and FIFO rules.
module tb_lif_tdm_scheduler;

  localparam int N    = 4;
  localparam int TH   = 200;
  localparam int DEC  = 1;
  localparam int REFR = 4;
  localparam int FD   = 4;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_enable = 1'b1;
  logic       i_tick = 1'b0;
  logic       i_in_valid = 1'b0;
  logic [1:0] i_in_idx = 2'd0;
  logic [7:0] i_in_value = 8'd0;
  logic       o_busy;
  logic       o_sweep_done;
  logic       o_spike_valid;
  logic       i_spike_ready = 1'b0;
  logic [1:0] o_spike_idx;
  logic       o_spike_dropped;
  logic [7:0] o_drop_count;
  logic [1:0] i_state_sel = 2'd0;
  logic [7:0] o_state_out;

  int checks = 0;
  int failures = 0;

  int m_mem  [N];
  int m_stim [N];
  int m_refr [N];
  int m_fifo [$];
  int m_cyc;
  int m_drops;
  bit m_dropped;

  lif_tdm_scheduler #(
    .N_NEURONS(N), .THRESHOLD(TH), .DECAY(DEC), .REFRACTORY(REFR), .FIFO_DEPTH(FD)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_tick(i_tick),
    .i_in_valid(i_in_valid), .i_in_idx(i_in_idx), .i_in_value(i_in_value),
    .o_busy(o_busy), .o_sweep_done(o_sweep_done), .o_spike_valid(o_spike_valid),
    .i_spike_ready(i_spike_ready), .o_spike_idx(o_spike_idx),
    .o_spike_dropped(o_spike_dropped), .o_drop_count(o_drop_count),
    .i_state_sel(i_state_sel), .o_state_out(o_state_out)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_mem[i] = 0; m_stim[i] = 0; m_refr[i] = 0;
    end
    m_fifo.delete();
    m_cyc = 0; m_drops = 0; m_dropped = 0;
  endtask

  task automatic check_outputs();
    chk("busy", int'(o_busy), int'(m_cyc != 0));
    chk("sweep_done", int'(o_sweep_done), int'(m_cyc == 2 * N + 1));
    chk("spike_valid", int'(o_spike_valid), int'(m_fifo.size() != 0));
    if (m_fifo.size() != 0) chk("spike_idx", int'(o_spike_idx), m_fifo[0]);
    chk("spike_dropped", int'(o_spike_dropped), int'(m_dropped));
    chk("drop_count", int'(o_drop_count), m_drops);
    chk("state_out", int'(o_state_out), m_mem[i_state_sel]);
  endtask

  // One clock: advance the model with the current inputs, then compare after the edge.
  task automatic step();
    bit upd, pop, fire, drop;
    int k, sum, leak, nxt;
    pop  = (m_fifo.size() != 0) && i_spike_ready;
    upd  = (m_cyc >= 2) && (m_cyc <= 2 * N) && (m_cyc % 2 == 0);
    k    = upd ? (m_cyc - 2) / 2 : 0;
    fire = 1'b0;
    drop = 1'b0;
    if (upd) begin
      if (m_refr[k] != 0) begin
        m_refr[k]--;
        m_mem[k] = 0;
      end else begin
        sum  = sat(m_mem[k] + m_stim[k]);
        leak = (m_mem[k] < DEC) ? m_mem[k] : DEC;
        nxt  = sum - leak;
        if (nxt >= TH) begin
          fire = 1'b1; m_mem[k] = 0; m_refr[k] = REFR;
        end else begin
          m_mem[k] = nxt;
        end
      end
      m_stim[k] = 0;
    end
    if (i_in_valid) m_stim[i_in_idx] = sat(m_stim[i_in_idx] + int'(i_in_value));
    if (pop) void'(m_fifo.pop_front());
    if (fire) begin
      if (m_fifo.size() >= FD) drop = 1'b1;
      else m_fifo.push_back(k);
    end
    if (drop && m_drops < 255) m_drops++;
    m_dropped = drop;
    if (m_cyc == 0)              m_cyc = (i_tick && i_enable) ? 1 : 0;
    else if (m_cyc == 2 * N + 1) m_cyc = 0;
    else                         m_cyc++;
    @(posedge i_clk);
    #1;
    check_outputs();
  endtask

  task automatic clear_inputs();
    i_tick = 1'b0; i_in_valid = 1'b0; i_in_idx = 2'd0; i_in_value = 8'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    model_clear();
    check_outputs();
  endtask

  task automatic write(input int idx, input int val);
    i_in_valid = 1'b1; i_in_idx = 2'(idx); i_in_value = 8'(val);
    step();
    i_in_valid = 1'b0;
  endtask

  task automatic sweep();
    i_tick = 1'b1;
    step();
    i_tick = 1'b0;
    for (int c = 0; c < 2 * N + 1; c++) step();
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step();
  endtask

  int exp2 [4] = '{50, 99, 148, 197};
  int n;

  initial begin
    model_clear();
    #2;
    do_reset();
    chk("reset_state", int'(o_state_out), 0);

    // Test 1: reset mid-sweep, then latency of a clean sweep.
    i_spike_ready = 1'b0;
    write(0, 50);
    write(1, 250);
    i_tick = 1'b1; step(); i_tick = 1'b0;
    for (int c = 0; c < 4; c++) step();
    chk("t1_pre_valid", int'(o_spike_valid), 1);
    i_reset = 1'b1;
    #1;
    chk("t1_rst_busy", int'(o_busy), 0);
    chk("t1_rst_valid", int'(o_spike_valid), 0);
    chk("t1_rst_state", int'(o_state_out), 0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    model_clear();
    i_tick = 1'b1; step(); i_tick = 1'b0;
    n = 1;
    while (!o_sweep_done && n < 20) begin step(); n++; end
    chk("t1_latency", n, 2 * N + 1);
    idle(2);

    // Test 2: integration and leak.
    do_reset();
    for (int j = 0; j < 4; j++) begin
      write(1, 50);
      sweep();
      i_state_sel = 2'd1; #1;
      chk("t2_state1", int'(o_state_out), exp2[j]);
      i_state_sel = 2'd0; #1;
      chk("t2_state0", int'(o_state_out), 0);
    end

    // Test 3: fire and refractory.
    do_reset();
    i_spike_ready = 1'b1;
    i_state_sel = 2'd2;
    for (int j = 0; j < 6; j++) begin
      write(2, 210);
      sweep();
      chk("t3_state2", int'(o_state_out), 0);
    end

    // Test 4: backpressure and drop.
    do_reset();
    i_spike_ready = 1'b0;
    for (int j = 0; j < 4; j++) write(j, 255);
    sweep();
    chk("t4_full_valid", int'(o_spike_valid), 1);
    chk("t4_head0", int'(o_spike_idx), 0);
    for (int j = 0; j < 4; j++) sweep();
    for (int j = 0; j < 4; j++) write(j, 255);
    sweep();
    chk("t4_drop_count", int'(o_drop_count), 4);
    chk("t4_head_still0", int'(o_spike_idx), 0);
    i_spike_ready = 1'b1;
    idle(6);

    // Test 5: collision write and ignored tick while busy.
    do_reset();
    i_tick = 1'b1; step(); i_tick = 1'b0;
    for (int c = 1; c <= 2 * N + 1; c++) begin
      i_tick = (c == 3);
      if (c == 8) begin
        i_in_valid = 1'b1; i_in_idx = 2'd3; i_in_value = 8'd30;
      end
      step();
      i_tick = 1'b0; i_in_valid = 1'b0;
    end
    idle(3);
    sweep();
    i_state_sel = 2'd3; #1;
    chk("t5_state3", int'(o_state_out), 30);

    // Test 6: stimulus saturation drives a spike.
    do_reset();
    i_spike_ready = 1'b0;
    i_state_sel = 2'd0;
    write(0, 200);
    write(0, 200);
    sweep();
    chk("t6_valid", int'(o_spike_valid), 1);
    chk("t6_idx", int'(o_spike_idx), 0);
    chk("t6_state0", int'(o_state_out), 0);
    i_spike_ready = 1'b1;
    idle(3);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      i_in_valid    = ($urandom_range(0, 1) == 1);
      i_in_idx      = 2'($urandom_range(0, N - 1));
      i_in_value    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(150, 255)) : 8'($urandom_range(0, 60));
      i_tick        = ($urandom_range(0, 5) == 0);
      i_enable      = ($urandom_range(0, 3) != 0);
      i_spike_ready = ($urandom_range(0, 2) != 0);
      i_state_sel   = 2'($urandom_range(0, N - 1));
      step();
    end
    clear_inputs();
    i_enable = 1'b1;
    idle(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
